prog_count_n: RTL and testbench

- Parametrised programmable counter; successor to the fixed 7-bit stop-at-max counter wrapper.
- Generalised width and ceiling, up/down direction, explicit start/load, terminal-count status and one-cycle done pulse.
- Used by lab timing/sequencing logic wherever a bounded, restartable count is needed.
- Drives 7-segment/display and control paths from count_out.

---
 rtl/prog_count_n.sv | 165 ++++++++++++++++
 tb/tb_prog_count_n.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_count_n.sv
`default_nettype none
// ============================================================================
//  Module   : prog_count_n
//  Purpose  : Parametrised programmable up/down counter with a latched
//             ceiling. It restarts on start, advances while run is high, and
//             reports completion as a one-cycle done pulse plus a held
//             terminal-count level.
//  Ports    : CLK        - system clock, rising edge
//             RST        - synchronous active-high reset
//             start      - one-cycle pulse; latches max_count/dir and (re)starts
//             run        - level enable for advancing the count
//             dir        - 0 = count up 0->target, 1 = count down target->0
//             max_count  - requested terminal value (clamped to LIMIT)
//             count_out  - current count (registered)
//             busy       - high while counting
//             done       - one-cycle pulse when the end value is reached
//             tc         - terminal-count level, high while finished
//  Options  : PROG_CNT_RELOAD_EN - when defined, the counter auto-reloads at
//             the end value and runs periodically instead of stopping.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_count_n #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 99
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             run,
    input  logic             dir,
    input  logic [WIDTH-1:0] max_count,
    output logic [WIDTH-1:0] count_out,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_COUNT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [WIDTH-1:0] c_LIMIT = WIDTH'(LIMIT);

`ifdef PROG_CNT_RELOAD_EN
    localparam logic c_RELOAD = 1'b1;
`else
    localparam logic c_RELOAD = 1'b0;
`endif

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_target;
    logic             r_dir;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_target_nxt;
    logic             w_dir_nxt;
    logic             w_done_nxt;

    logic [WIDTH-1:0] w_tgt_new;
    logic [WIDTH-1:0] w_start_new;
    logic [WIDTH-1:0] w_end_val;
    logic [WIDTH-1:0] w_reload_val;
    logic [WIDTH-1:0] w_step;

    // Values for a fresh start come from the live inputs; values for an
    // ongoing count come only from the latched target/direction.
    assign w_tgt_new    = (max_count > c_LIMIT) ? c_LIMIT : max_count;
    assign w_start_new  = dir ? w_tgt_new : '0;
    assign w_end_val    = r_dir ? '0 : r_target;
    assign w_reload_val = r_dir ? r_target : '0;
    assign w_step       = r_dir ? (r_count - 1'b1) : (r_count + 1'b1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_target <= '0;
            r_dir    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
            r_dir    <= w_dir_nxt;
            r_done   <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-count logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        w_dir_nxt    = r_dir;
        w_done_nxt   = 1'b0;

        if (start) begin
            // start wins in every state; an in-flight count is abandoned
            // silently.
            w_target_nxt = w_tgt_new;
            w_dir_nxt    = dir;
            w_count_nxt  = w_start_new;
            if (w_tgt_new == '0) begin
                // Start and end coincide: finish on the start edge itself.
                w_state_nxt = c_DONE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = c_COUNT;
            end
        end else begin
            case (r_state)
                c_COUNT: begin
                    if (run) begin
                        if (r_count != w_end_val) begin
                            w_count_nxt = w_step;
                            if (w_step == w_end_val) begin
                                w_done_nxt = 1'b1;
                                if (!c_RELOAD) begin
                                    w_state_nxt = c_DONE;
                                end
                            end
                        end else if (c_RELOAD) begin
                            // Sitting on the end value only happens in
                            // auto-reload mode; restart the period here.
                            w_count_nxt = w_reload_val;
                        end
                    end
                end
                c_DONE: begin
                    // Only the zero-target case parks here in reload mode;
                    // every advancing cycle is then a complete period.
                    if (c_RELOAD && run) begin
                        w_done_nxt = 1'b1;
                    end
                end
                c_IDLE: begin
                    w_state_nxt = c_IDLE;
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registers only
    // ------------------------------------------------------------------
    always_comb begin
        count_out = r_count;
        done      = r_done;
        busy      = (r_state == c_COUNT);
        tc        = (r_state == c_DONE) && !c_RELOAD;
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_count_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_count_n
//  Purpose  : Self-checking bench for prog_count_n. A behavioural model
//             tracks count, target and completion per clock edge from the
//             counter's rules; each scenario task compares the DUT against
//             it, plus explicit constants for the headline cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_count_n;

    localparam int WIDTH = 7;
    localparam int LIMIT = 99;
`ifdef PROG_CNT_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             start = 1'b0;
    logic             run = 1'b0;
    logic             dir = 1'b0;
    logic [WIDTH-1:0] max_count = '0;
    logic [WIDTH-1:0] count_out;
    logic             busy;
    logic             done;
    logic             tc;

    int checks = 0;
    int errors = 0;

    // Model: m_phase 0 = idle, 1 = counting, 2 = finished
    int m_cnt   = 0;
    int m_tgt   = 0;
    bit m_down  = 0;
    int m_phase = 0;
    bit m_done  = 0;

    prog_count_n #(.WIDTH(WIDTH), .LIMIT(LIMIT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .run       (run),
        .dir       (dir),
        .max_count (max_count),
        .count_out (count_out),
        .busy      (busy),
        .done      (done),
        .tc        (tc)
    );

    always #5 CLK = ~CLK;

    task automatic model_edge();
        int fin;
        m_done = 0;
        if (RST) begin
            m_cnt = 0; m_tgt = 0; m_down = 0; m_phase = 0;
        end else if (start) begin
            m_tgt  = (int'(max_count) > LIMIT) ? LIMIT : int'(max_count);
            m_down = dir;
            m_cnt  = m_down ? m_tgt : 0;
            if (m_tgt == 0) begin
                m_phase = 2; m_done = 1;
            end else begin
                m_phase = 1;
            end
        end else if (m_phase == 1 && run) begin
            fin = m_down ? 0 : m_tgt;
            if (m_cnt == fin) begin
                m_cnt = m_down ? m_tgt : 0;
            end else begin
                m_cnt = m_down ? m_cnt - 1 : m_cnt + 1;
                if (m_cnt == fin) begin
                    m_done = 1;
                    if (!RELOAD) m_phase = 2;
                end
            end
        end else if (m_phase == 2 && RELOAD && run) begin
            m_done = 1;
        end
    endtask

    function automatic logic [WIDTH+2:0] exp_vec();
        return {WIDTH'(m_cnt), m_phase == 1, m_done, (m_phase == 2) && !RELOAD};
    endfunction

    function automatic logic [WIDTH+2:0] act_vec();
        return {count_out, busy, done, tc};
    endfunction

    // Inputs change at negedge; DUT and model both consume them at posedge;
    // outputs are compared at the following negedge.
    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1; start = 0; run = 0;
        cycle(); cycle();
        checks++;
        if (act_vec() !== exp_vec() || count_out !== 0 || busy !== 0 || done !== 0 || tc !== 0) begin
            errors++;
            $display("FAIL reset_init: got %h exp %h", act_vec(), exp_vec());
        end
        RST = 0;
        // Count up toward 10, then reset while showing 5
        max_count = 10; dir = 0; run = 1; start = 1;
        cycle(); start = 0;
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (count_out !== 5) begin
            errors++;
            $display("FAIL reset_precount: got %0d exp 5", count_out);
        end
        RST = 1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (act_vec() !== exp_vec() || count_out !== 0 || busy !== 0 || done !== 0 || tc !== 0) begin
                errors++;
                $display("FAIL reset_midcount %0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
        RST = 0;
        cycle();
        checks++;
        if (act_vec() !== exp_vec() || busy !== 0) begin
            errors++;
            $display("FAIL reset_idle_hold: got %h exp %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_up_basic();
        int ndone = 0;
        max_count = 3; dir = 0; run = 1; start = 1;
        cycle(); start = 0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL up_basic cyc%0d: got %h exp %h", i, act_vec(), exp_vec());
            end
            if (done) ndone++;
            if (i == 3) begin
                checks++;
                if (count_out !== 3 || done !== 1) begin
                    errors++;
                    $display("FAIL up_basic_end: got cnt=%0d done=%b exp cnt=3 done=1", count_out, done);
                end
            end
            cycle();
        end
        checks++;
        if (ndone !== 1 || count_out !== 3 || tc !== !RELOAD && !RELOAD) begin
            errors++;
            $display("FAIL up_basic_hold: got done_pulses=%0d cnt=%0d tc=%b exp 1/3/1", ndone, count_out, tc);
        end
    endtask

    task automatic test_down_clamp();
        int ndone = 0;
        max_count = 120; dir = 1; run = 1; start = 1;
        cycle(); start = 0;
        checks++;
        if (count_out !== 99 || busy !== 1) begin
            errors++;
            $display("FAIL down_load: got cnt=%0d busy=%b exp 99/1", count_out, busy);
        end
        for (int i = 0; i < 102; i++) begin
            cycle();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL down_clamp cyc%0d: got %h exp %h", i, act_vec(), exp_vec());
            end
            if (done) ndone++;
        end
        if (!RELOAD) begin
            checks++;
            if (ndone !== 1 || count_out !== 0 || tc !== 1) begin
                errors++;
                $display("FAIL down_end: got pulses=%0d cnt=%0d tc=%b exp 1/0/1", ndone, count_out, tc);
            end
        end
    endtask

    task automatic test_run_pause();
        max_count = 10; dir = 0; run = 1; start = 1;
        cycle(); start = 0;
        for (int i = 0; i < 4; i++) cycle();
        run = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (act_vec() !== exp_vec() || count_out !== 4 || busy !== 1) begin
                errors++;
                $display("FAIL pause_hold cyc%0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
        run = 1;
        for (int i = 0; i < 7; i++) begin
            cycle();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pause_resume cyc%0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_restart();
        max_count = 9; dir = 0; run = 1; start = 1;
        cycle(); start = 0;
        for (int i = 0; i < 6; i++) cycle();
        max_count = 2; start = 1;
        cycle(); start = 0;
        checks++;
        if (count_out !== 0 || done !== 0 || busy !== 1) begin
            errors++;
            $display("FAIL restart_load: got cnt=%0d done=%b busy=%b exp 0/0/1", count_out, done, busy);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL restart cyc%0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
        // Degenerate zero target, with run low to show run is irrelevant
        max_count = 0; run = 0; start = 1;
        cycle(); start = 0;
        checks++;
        if (act_vec() !== exp_vec() || done !== 1 || count_out !== 0 || tc !== !RELOAD) begin
            errors++;
            $display("FAIL zero_target: got %h exp %h", act_vec(), exp_vec());
        end
        cycle();
        checks++;
        if (act_vec() !== exp_vec() || done !== 0) begin
            errors++;
            $display("FAIL zero_target_after: got %h exp %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_reload();
        max_count = 2; dir = 0; run = 1; start = 1;
        cycle(); start = 0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (act_vec() !== exp_vec() || tc !== 0 || done !== (count_out == 2)) begin
                errors++;
                $display("FAIL reload cyc%0d: got %h exp %h", i, act_vec(), exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            RST   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 14) == 0);
            run   = ($urandom_range(0, 3) != 0);
            dir   = $urandom_range(0, 1);
            max_count = ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 12))
                                                    : WIDTH'($urandom_range(0, 127));
            cycle();
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d: got %h exp %h", i, act_vec(), exp_vec());
            end
        end
        RST = 0; start = 0;
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_up_basic();
        test_down_clamp();
        test_run_pause();
        test_restart();
        if (RELOAD) test_reload();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
